// File: rtl/painterengine_gpu_writer_fifo_pkg.sv
// Shared GPU definitions: writer-FIFO and DMA-writer state encodings plus the
// default pixel-stream width and FIFO depth.
package painterengine_gpu_writer_fifo_pkg;

    localparam int GPU_DATA_WIDTH = 32;
    localparam int GPU_FIFO_DEPTH = 64;

    typedef enum logic [2:0] {
        FIFO_IDLE  = 3'd0,
        FIFO_FILL  = 3'd1,
        FIFO_DRAIN = 3'd2,
        FIFO_DONE  = 3'd3,
        FIFO_ERROR = 3'd4
    } fifo_state_t;

    typedef enum logic [2:0] {
        WRITER_IDLE  = 3'd0,
        WRITER_ADDR  = 3'd1,
        WRITER_BURST = 3'd2,
        WRITER_RESP  = 3'd3,
        WRITER_DONE  = 3'd4,
        WRITER_ERROR = 3'd5
    } writer_state_t;

    // Occupancy needs one bit more than the address so that "full" is representable.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/painterengine_gpu_writer_fifo_if.sv
// Pixel-stream bundle around the writer FIFO: producer side (rasterizer words in)
// and consumer side (head word out to the DMA writer).
interface painterengine_gpu_writer_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    // Producer: a word moves when in_valid && in_ready at a rising edge.
    // Consumer: data is valid whenever data_valid is high; data_next consumes it.
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] data;
    logic                  data_valid;
    logic                  data_next;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output data,
        output data_valid,
        input  data_next
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  data,
        input  data_valid,
        output data_next
    );

endinterface

// File: rtl/painterengine_gpu_sync_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module painterengine_gpu_sync_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/painterengine_gpu_writer_fifo.sv
// Job-scoped FWFT buffer between the rasterizer and the DMA writer: accepts exactly
// `length` words, streams them out in order, and ends sticky DONE or ERROR.
module painterengine_gpu_writer_fifo
    import painterengine_gpu_writer_fifo_pkg::*;
#(
    parameter int PARAM_DATA_WIDTH = GPU_DATA_WIDTH,
    parameter int PARAM_FIFO_DEPTH = GPU_FIFO_DEPTH
) (
    input  logic                                i_wire_clock,
    input  logic                                i_wire_resetn,
    input  logic                                i_wire_start,
    input  logic [31:0]                         i_wire_length,
    input  logic [PARAM_DATA_WIDTH-1:0]         i_wire_in_data,
    input  logic                                i_wire_in_valid,
    output logic                                o_wire_in_ready,
    output logic [PARAM_DATA_WIDTH-1:0]         o_wire_data,
    output logic                                o_wire_data_valid,
    input  logic                                i_wire_data_next,
    input  logic                                i_wire_writer_done,
    input  logic                                i_wire_writer_error,
    output logic [$clog2(PARAM_FIFO_DEPTH):0]   o_wire_level,
    output logic                                o_wire_done,
    output logic                                o_wire_error
);

    localparam int ADDR_W  = $clog2(PARAM_FIFO_DEPTH);
    localparam int LEVEL_W = level_width(PARAM_FIFO_DEPTH);
    localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(PARAM_FIFO_DEPTH);

    fifo_state_t        state;
    logic [LEVEL_W-1:0] wr_ptr;
    logic [LEVEL_W-1:0] rd_ptr;
    logic [LEVEL_W-1:0] level;
    logic [31:0]        length_q;
    logic [31:0]        in_count;
    logic [31:0]        out_count;

    logic active;
    logic in_ready;
    logic push;
    logic pop;
    logic underflow;
    logic overrun;

    // The wrap bit makes wr_ptr - rd_ptr the true occupancy, including full.
    assign level     = wr_ptr - rd_ptr;
    assign active    = (state == FIFO_FILL) || (state == FIFO_DRAIN);
    assign in_ready  = (state == FIFO_FILL) && (level < FULL_LEVEL) && (in_count < length_q);
    assign push      = i_wire_in_valid && in_ready;
    assign pop       = active && i_wire_data_next && (level != '0);
    assign underflow = active && i_wire_data_next && (level == '0);
    assign overrun   = out_count > length_q;

    assign o_wire_in_ready   = in_ready;
    assign o_wire_data_valid = active && (level != '0);
    assign o_wire_level      = level;
    assign o_wire_done       = (state == FIFO_DONE);
    assign o_wire_error      = (state == FIFO_ERROR);

    painterengine_gpu_sync_ram #(
        .DATA_WIDTH (PARAM_DATA_WIDTH),
        .ADDR_WIDTH (ADDR_W)
    ) u_ram (
        .clock   (i_wire_clock),
        .wr_en   (push),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (i_wire_in_data),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (o_wire_data)
    );

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state     <= FIFO_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            length_q  <= '0;
            in_count  <= '0;
            out_count <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                in_count <= in_count + 32'd1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                out_count <= out_count + 32'd1;
            end

            case (state)
                FIFO_IDLE: begin
                    if (i_wire_start) begin
                        if (i_wire_length == 32'd0) begin
                            state <= FIFO_ERROR;
                        end else begin
                            length_q  <= i_wire_length;
                            in_count  <= '0;
                            out_count <= '0;
                            wr_ptr    <= '0;
                            rd_ptr    <= '0;
                            state     <= FIFO_FILL;
                        end
                    end
                end

                FIFO_FILL, FIFO_DRAIN: begin
                    // Writer error outranks everything, then local protocol faults.
                    if (i_wire_writer_error) begin
                        state <= FIFO_ERROR;
                    end else if (underflow || overrun) begin
                        state <= FIFO_ERROR;
                    end else if (state == FIFO_FILL) begin
                        if (in_count == length_q) begin
                            state <= FIFO_DRAIN;
                        end
                    end else if ((out_count == length_q) && i_wire_writer_done) begin
                        state <= FIFO_DONE;
                    end
                end

                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_painterengine_gpu_writer_fifo.sv
// Directed bench for the writer FIFO: scoreboard of accepted words checked against
// the head-word stream, plus the error/terminal/reset scenarios.
module tb_painterengine_gpu_writer_fifo;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [31:0] length;
    logic        writer_done;
    logic        writer_error;
    logic [6:0]  level;
    logic        done;
    logic        error;

    painterengine_gpu_writer_fifo_if #(.DATA_WIDTH(32)) bus ();

    painterengine_gpu_writer_fifo dut (
        .i_wire_clock        (clock),
        .i_wire_resetn       (resetn),
        .i_wire_start        (start),
        .i_wire_length       (length),
        .i_wire_in_data      (bus.in_data),
        .i_wire_in_valid     (bus.in_valid),
        .o_wire_in_ready     (bus.in_ready),
        .o_wire_data         (bus.data),
        .o_wire_data_valid   (bus.data_valid),
        .i_wire_data_next    (bus.data_next),
        .i_wire_writer_done  (writer_done),
        .i_wire_writer_error (writer_error),
        .o_wire_level        (level),
        .o_wire_done         (done),
        .o_wire_error        (error)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // scoreboard state
    logic [31:0] exp_q[$];
    int          checks;
    int          failures;
    int          sent;
    int          received;
    int          job_len;
    logic [31:0] next_word;
    bit          use_table;
    logic [31:0] word_tbl [4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gen_word(input int idx);
        if (use_table && idx < 4) return word_tbl[idx];
        return $urandom;
    endfunction

    task automatic do_reset();
        resetn       = 1'b0;
        start        = 1'b0;
        length       = '0;
        writer_done  = 1'b0;
        writer_error = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.data_next = 1'b0;
        exp_q.delete();
        sent     = 0;
        received = 0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic start_job(input int len);
        @(negedge clock);
        start     = 1'b1;
        length    = 32'(len);
        job_len   = len;
        sent      = 0;
        received  = 0;
        next_word = gen_word(0);
        @(negedge clock);
        start = 1'b0;
    endtask

    // driver: one cycle of producer and consumer activity, decided at the falling edge
    task automatic step(input bit prod_en, input bit cons_en);
        @(negedge clock);
        if (cons_en && bus.data_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 64'(bus.data), 64'hDEAD_BEEF_DEAD_BEEF);
            end else begin
                check("word_order", 64'(bus.data), 64'(exp_q.pop_front()));
            end
            received++;
            bus.data_next = 1'b1;
        end else begin
            bus.data_next = 1'b0;
        end
        if (prod_en && sent < job_len) begin
            bus.in_valid = 1'b1;
            bus.in_data  = next_word;
            if (bus.in_ready) begin
                exp_q.push_back(next_word);
                sent++;
                next_word = gen_word(sent);
            end
        end else begin
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic run_to_done(input int budget);
        int n;
        n = 0;
        while (received < job_len && n < budget) begin
            step(1'b1, 1'b1);
            n++;
        end
        step(1'b0, 1'b0);
        writer_done = 1'b1;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("job_done", 64'(done), 64'd1);
        check("job_error", 64'(error), 64'd0);
        check("level_empty", 64'(level), 64'd0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("word_count", 64'(received), 64'(job_len));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        use_table = 1'b0;
        word_tbl[0] = 32'hAAAA_0001;
        word_tbl[1] = 32'hBBBB_0002;
        word_tbl[2] = 32'hCCCC_0003;
        word_tbl[3] = 32'hDDDD_0004;

        // reset state
        do_reset();
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_data_valid", 64'(bus.data_valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);

        // four words A..D back-to-back with an eager consumer
        use_table = 1'b1;
        start_job(4);
        check("fill_in_ready", 64'(bus.in_ready), 64'd1);
        run_to_done(40);
        use_table = 1'b0;

        // 80 words into a 64-deep buffer with the consumer stalled
        do_reset();
        start_job(80);
        repeat (100) step(1'b1, 1'b0);
        check("stall_level_full", 64'(level), 64'd64);
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        check("stall_sent", 64'(sent), 64'd64);
        check("stall_valid", 64'(bus.data_valid), 64'd1);
        run_to_done(400);

        // zero-length job
        do_reset();
        start_job(0);
        check("len0_error", 64'(error), 64'd1);
        check("len0_in_ready", 64'(bus.in_ready), 64'd0);
        repeat (3) @(negedge clock);
        check("len0_in_ready_hold", 64'(bus.in_ready), 64'd0);
        check("len0_error_sticky", 64'(error), 64'd1);

        // data_next while empty in FILL
        do_reset();
        start_job(8);
        check("uf_fill", 64'(bus.in_ready), 64'd1);
        check("uf_empty", 64'(level), 64'd0);
        bus.data_next = 1'b1;
        @(negedge clock);
        bus.data_next = 1'b0;
        check("uf_error", 64'(error), 64'd1);
        check("uf_data_valid", 64'(bus.data_valid), 64'd0);

        // writer error while draining ten words; start is ignored afterwards
        do_reset();
        start_job(10);
        repeat (15) step(1'b1, 1'b0);
        check("werr_level", 64'(level), 64'd10);
        check("werr_valid_before", 64'(bus.data_valid), 64'd1);
        check("werr_in_ready_drain", 64'(bus.in_ready), 64'd0);
        writer_error = 1'b1;
        @(negedge clock);
        writer_error = 1'b0;
        check("werr_error", 64'(error), 64'd1);
        check("werr_data_valid", 64'(bus.data_valid), 64'd0);
        check("werr_done", 64'(done), 64'd0);
        start = 1'b1;
        length = 32'd3;
        @(negedge clock);
        start = 1'b0;
        check("werr_terminal", 64'(error), 64'd1);

        // asynchronous reset mid-job with twenty words buffered
        do_reset();
        start_job(30);
        while (sent < 20) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("mid_level", 64'(level), 64'd20);
        #2;
        resetn = 1'b0;
        #1;
        check("async_level", 64'(level), 64'd0);
        check("async_in_ready", 64'(bus.in_ready), 64'd0);
        check("async_data_valid", 64'(bus.data_valid), 64'd0);
        check("async_done", 64'(done), 64'd0);
        check("async_error", 64'(error), 64'd0);
        do_reset();
        start_job(2);
        run_to_done(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
